// File: rtl/mac_acc_pkg.sv
// mac_acc_pkg: shared widths and sign-extension helper for the MAC accumulate stage.
package mac_acc_pkg;
   localparam int PROD_W = 16;
   localparam int ACC_W  = 32;
   localparam int OUT_W  = 8;
   localparam int CNT_W  = 16;
   localparam int SH_W   = 4;

   function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
      return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
   endfunction
endpackage

// File: rtl/acc_round_sat.sv
// acc_round_sat: round-half-up arithmetic right shift of a wide sum, then saturate to OUT_W.
module acc_round_sat
   import mac_acc_pkg::*;
#(
   parameter int AW = ACC_W,
   parameter int OW = OUT_W,
   parameter int SW = SH_W
) (
   input  logic [AW-1:0] sum_i,
   input  logic [SW-1:0] shift_i,
   output logic [OW-1:0] data_o,
   output logic          sat_o
);
   localparam logic signed [AW:0] HI = (AW+1)'((2 ** (OW-1)) - 1);
   localparam logic signed [AW:0] LO = ~HI;

   logic signed [AW:0] ext, rnd, r;

   // One guard bit keeps the rounding add from overflowing the sum width.
   always_comb begin
      ext    = {sum_i[AW-1], sum_i};
      rnd    = (shift_i == '0) ? '0 : (AW+1)'(1) << (shift_i - SW'(1));
      r      = $signed(ext + rnd) >>> shift_i;
      sat_o  = (r > HI) || (r < LO);
      data_o = (r > HI) ? HI[OW-1:0] : (r < LO) ? LO[OW-1:0] : r[OW-1:0];
   end
endmodule

// File: rtl/mac_accum_stage.sv
// mac_accum_stage: accumulates signed product windows and emits raw and rounded/saturated
// results through a one-deep output register with valid/ready handshakes.
module mac_accum_stage
   import mac_acc_pkg::*;
(
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rstn,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod_data,
   input  logic              prod_last,
   input  logic [SH_W-1:0]   cfg_shift,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_raw,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_sat,
   output logic [CNT_W-1:0]  out_cnt
);
   logic [ACC_W-1:0] acc_q, acc_d, raw_q, raw_d, sum;
   logic [CNT_W-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d;
   logic [OUT_W-1:0] data_q, data_d, rs_data;
   logic             valid_q, valid_d, sat_q, sat_d, rs_sat, accept;

   assign prod_ready = !valid_q || out_ready;
   assign accept     = prod_valid && prod_ready;
   assign sum        = acc_q + sext_prod(prod_data);

   acc_round_sat u_rs (
      .sum_i   (sum),
      .shift_i (cfg_shift),
      .data_o  (rs_data),
      .sat_o   (rs_sat)
   );

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      raw_d   = raw_q;
      ocnt_d  = ocnt_q;
      data_d  = data_q;
      sat_d   = sat_q;
      valid_d = valid_q && !out_ready;
      if (accept && prod_last) begin
         acc_d   = '0;
         cnt_d   = '0;
         raw_d   = sum;
         ocnt_d  = cnt_q + CNT_W'(1);
         data_d  = rs_data;
         sat_d   = rs_sat;
         valid_d = 1'b1;
      end else if (accept) begin
         acc_d = sum;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         raw_q   <= '0;
         ocnt_q  <= '0;
         data_q  <= '0;
         sat_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         raw_q   <= raw_d;
         ocnt_q  <= ocnt_d;
         data_q  <= data_d;
         sat_q   <= sat_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign out_raw   = raw_q;
   assign out_data  = data_q;
   assign out_sat   = sat_q;
   assign out_cnt   = ocnt_q;
endmodule

// File: tb/tb_mac_accum_stage.sv
// tb_mac_accum_stage: directed window vectors plus backpressure and mid-window reset sequences.
module tb_mac_accum_stage;
   logic        clk = 1'b0, rstn = 1'b0;
   logic        prod_valid = 1'b0, prod_ready, prod_last = 1'b0;
   logic [15:0] prod_data = '0;
   logic [3:0]  cfg_shift = '0;
   logic        out_valid, out_ready = 1'b1, out_sat;
   logic [31:0] out_raw;
   logic [7:0]  out_data;
   logic [15:0] out_cnt;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   mac_accum_stage dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .prod_valid      (prod_valid),
      .prod_ready      (prod_ready),
      .prod_data       (prod_data),
      .prod_last       (prod_last),
      .cfg_shift       (cfg_shift),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_raw         (out_raw),
      .out_data        (out_data),
      .out_sat         (out_sat),
      .out_cnt         (out_cnt)
   );

   typedef struct {
      logic [3:0][15:0] d;
      int               n;
      logic [3:0]       sh;
      logic [31:0]      raw;
      logic [7:0]       dat;
      logic             sat;
      logic [15:0]      cnt;
   } vec_t;

   vec_t tbl[11];

   function automatic vec_t mk(input logic [15:0] d0, d1, d2, d3, input int n, input logic [3:0] sh,
                               input logic [31:0] raw, input logic [7:0] dat, input logic sat);
      vec_t v;
      v.d   = {d3, d2, d1, d0};
      v.n   = n;
      v.sh  = sh;
      v.raw = raw;
      v.dat = dat;
      v.sat = sat;
      v.cnt = 16'(n);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic beat(input logic [15:0] d, input logic last, input logic [3:0] sh);
      @(negedge clk);
      prod_valid = 1'b1;
      prod_data  = d;
      prod_last  = last;
      cfg_shift  = sh;
      @(posedge clk);
      #1;
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      prod_data  = 16'hxxxx;
   endtask

   initial begin
      tbl[0]  = mk(16'h0006, 16'hFFF4, 16'h0064, 16'h0002, 4, 4'd0, 32'd96, 8'h60, 1'b0);
      tbl[1]  = mk(16'h3F01, 0, 0, 0, 1, 4'd4, 32'd16129, 8'h7F, 1'b1);
      tbl[2]  = mk(16'hFF38, 0, 0, 0, 1, 4'd0, 32'hFFFFFF38, 8'h80, 1'b1);
      tbl[3]  = mk(16'd24, 0, 0, 0, 1, 4'd4, 32'd24, 8'h02, 1'b0);
      tbl[4]  = mk(16'hFFE8, 0, 0, 0, 1, 4'd4, 32'hFFFFFFE8, 8'hFF, 1'b0);
      tbl[5]  = mk(16'd23, 0, 0, 0, 1, 4'd4, 32'd23, 8'h01, 1'b0);
      tbl[6]  = mk(16'd127, 0, 0, 0, 1, 4'd0, 32'd127, 8'h7F, 1'b0);
      tbl[7]  = mk(16'd128, 0, 0, 0, 1, 4'd0, 32'd128, 8'h7F, 1'b1);
      tbl[8]  = mk(16'hFF80, 0, 0, 0, 1, 4'd0, 32'hFFFFFF80, 8'h80, 1'b0);
      tbl[9]  = mk(16'hFF7F, 0, 0, 0, 1, 4'd0, 32'hFFFFFF7F, 8'h80, 1'b1);
      tbl[10] = mk(16'h7FFF, 16'h7FFF, 0, 0, 2, 4'd15, 32'd65534, 8'h02, 1'b0);

      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_raw", out_raw, 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_sat", 32'(out_sat), 0);
      chk("rst_cnt", 32'(out_cnt), 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(prod_ready), 1);

      for (int i = 0; i < 11; i++) begin
         for (int b = 0; b < tbl[i].n; b++) beat(tbl[i].d[b], b == tbl[i].n - 1, tbl[i].sh);
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
         chk($sformatf("v%0d_raw", i), out_raw, tbl[i].raw);
         chk($sformatf("v%0d_data", i), 32'(out_data), 32'(tbl[i].dat));
         chk($sformatf("v%0d_sat", i), 32'(out_sat), 32'(tbl[i].sat));
         chk($sformatf("v%0d_cnt", i), 32'(out_cnt), 32'(tbl[i].cnt));
      end
      @(negedge clk);
      chk("drain_valid", 32'(out_valid), 0);

      out_ready = 1'b0;
      beat(16'd50, 1'b1, 4'd0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_ready", 32'(prod_ready), 0);
         chk("bp_raw", out_raw, 50);
         chk("bp_data", 32'(out_data), 50);
      end
      prod_valid = 1'b1;
      prod_data  = 16'd70;
      prod_last  = 1'b1;
      out_ready  = 1'b1;
      #1;
      chk("bp_ready_up", 32'(prod_ready), 1);
      @(posedge clk);
      #1;
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      @(negedge clk);
      chk("bp2_valid", 32'(out_valid), 1);
      chk("bp2_raw", out_raw, 70);
      chk("bp2_cnt", 32'(out_cnt), 1);
      @(negedge clk);
      chk("bp2_drain", 32'(out_valid), 0);

      beat(16'd1, 1'b0, 4'd0);
      beat(16'd2, 1'b0, 4'd0);
      beat(16'd3, 1'b0, 4'd0);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 0);
      rstn = 1'b1;
      beat(16'd5, 1'b0, 4'd0);
      beat(16'd7, 1'b1, 4'd0);
      @(negedge clk);
      chk("mid_valid", 32'(out_valid), 1);
      chk("mid_raw", out_raw, 12);
      chk("mid_cnt", 32'(out_cnt), 2);
      chk("mid_data", 32'(out_data), 12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
